// File: rtl/mario_sprite_linebuf.sv
// mario_sprite_linebuf
// Per-scanline sprite fetch stage. During hblank one sprite row is read from
// the sprite ROM into a back line buffer, then copied to the front buffer.
// During active video the front buffer is looked up by draw_x, and the
// resulting palette index and opaque flag are produced one cycle later.
//
// Ports:
//   Clk, Reset   clock, asynchronous active-high reset
//   line_start   hblank start pulse; latches next_y/spr_y/flip_h, starts a fetch
//   next_y       scanline shown after this hblank
//   spr_x/spr_y  sprite top-left position (screen coordinates)
//   flip_h       horizontal mirror, sampled on line_start
//   rom_addr     sprite ROM address; rom_q returns one cycle later
//   draw_x       current active-video column
//   pix_index    palette index for draw_x, registered
//   pix_opaque   sprite covers draw_x and index is not transparent
//   busy         fetch or commit in progress
//
// state  | meaning
// IDLE   | waiting for line_start
// FETCH  | issuing ROM reads and filling the back buffer
// COMMIT | copy back -> front (hit) or blank the sprite line (miss)
module mario_sprite_linebuf #(
  parameter int          SPR_W        = 16,
  parameter int          SPR_H        = 16,
  parameter logic [3:0]  TRANSP_INDEX = 4'h0,
  parameter int          ROM_AW       = $clog2(SPR_W*SPR_H)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              line_start,
  input  logic [9:0]        next_y,
  input  logic [9:0]        spr_x,
  input  logic [9:0]        spr_y,
  input  logic              flip_h,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  input  logic [9:0]        draw_x,
  output logic [3:0]        pix_index,
  output logic              pix_opaque,
  output logic              busy
);

  localparam int OW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam int CW = $clog2(SPR_W+1);

  typedef enum logic [1:0] {IDLE, FETCH, COMMIT} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     row_l;
  logic              flip_l;
  logic              hit_l;
  logic              front_hit;
  logic [3:0]        back  [SPR_W];
  logic [3:0]        front [SPR_W];

  logic              hit_now;
  logic [RW-1:0]     row_now;
  logic [ROM_AW-1:0] base_now;
  logic [ROM_AW-1:0] base_l;
  logic [OW-1:0]     wcol;
  logic [OW-1:0]     widx;
  logic              in_x;
  logic [OW-1:0]     offs;
  logic [3:0]        fpix;

  // 11-bit compares so spr_y+SPR_H / spr_x+SPR_W never wrap.
  assign hit_now  = ({1'b0, next_y} >= {1'b0, spr_y}) &&
                    ({1'b0, next_y} <  ({1'b0, spr_y} + 11'(SPR_H)));
  assign row_now  = RW'(next_y - spr_y);
  assign base_now = ROM_AW'(row_now) * ROM_AW'(SPR_W);
  assign base_l   = ROM_AW'(row_l) * ROM_AW'(SPR_W);

  // cnt is one ahead of the column being written: rom_q for column c is
  // present while cnt == c+1.
  assign wcol = OW'(cnt - CW'(1));
  assign widx = flip_l ? (OW'(SPR_W-1) - wcol) : wcol;

  assign in_x = front_hit && ({1'b0, draw_x} >= {1'b0, spr_x}) &&
                ({1'b0, draw_x} < ({1'b0, spr_x} + 11'(SPR_W)));
  assign offs = OW'(draw_x - spr_x);
  assign fpix = front[offs];

  assign busy = (state != IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (line_start) begin
      state_nx = hit_now ? FETCH : COMMIT;
    end else begin
      case (state)
        FETCH:   if (cnt == CW'(SPR_W)) state_nx = COMMIT;
        COMMIT:  state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr   <= '0;
      cnt        <= '0;
      row_l      <= '0;
      flip_l     <= 1'b0;
      hit_l      <= 1'b0;
      front_hit  <= 1'b0;
      pix_index  <= 4'h0;
      pix_opaque <= 1'b0;
    end else begin
      if (line_start) begin
        row_l  <= row_now;
        flip_l <= flip_h;
        hit_l  <= hit_now;
        cnt    <= '0;
        if (hit_now) rom_addr <= base_now;
      end else if (state == FETCH) begin
        if (cnt < CW'(SPR_W-1)) rom_addr <= base_l + ROM_AW'(cnt) + ROM_AW'(1);
        if (cnt != CW'(SPR_W))  cnt <= cnt + CW'(1);
      end else if (state == COMMIT) begin
        front_hit <= hit_l;
      end
      pix_index  <= in_x ? fpix : 4'h0;
      pix_opaque <= in_x && (fpix != TRANSP_INDEX);
    end
  end

  // Line buffers carry no reset; front_hit masks them until the first commit.
  always_ff @(posedge Clk) begin
    if (!line_start && state == FETCH && cnt != '0) back[widx] <= rom_q;
    if (!line_start && state == COMMIT && hit_l) begin
      for (int i = 0; i < SPR_W; i++) front[i] <= back[i];
    end
  end

endmodule

// File: tb/tb_mario_sprite_linebuf.sv
module tb_mario_sprite_linebuf;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       line_start;
  logic [9:0] next_y, spr_x, spr_y, draw_x;
  logic       flip_h;
  logic [7:0] rom_addr;
  logic [3:0] rom_q;
  logic [3:0] pix_index;
  logic       pix_opaque;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] rom [256];
  int         front_m [16];
  bit         fhit_m;

  always #5 Clk = ~Clk;

  always @(posedge Clk) rom_q <= rom[rom_addr];

  mario_sprite_linebuf dut (
    .Clk(Clk), .Reset(Reset), .line_start(line_start), .next_y(next_y),
    .spr_x(spr_x), .spr_y(spr_y), .flip_h(flip_h), .rom_addr(rom_addr),
    .rom_q(rom_q), .draw_x(draw_x), .pix_index(pix_index),
    .pix_opaque(pix_opaque), .busy(busy)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int exp_idx(input int dx);
    int sx = int'(spr_x);
    if (fhit_m && dx >= sx && dx < sx + 16) return front_m[dx - sx];
    return 0;
  endfunction

  // Runs one hblank fetch; abort_after > 0 returns after that many cycles
  // without completing (model untouched, like the DUT's front buffer).
  task automatic do_line(input int ny, input bit fl, input int dx, input int abort_after);
    int  sy, row, a0, nbusy;
    bit  hit;
    sy  = int'(spr_y);
    hit = (ny >= sy) && (ny < sy + 16);
    row = ny - sy;
    a0  = int'(rom_addr);
    @(negedge Clk);
    next_y = 10'(ny); flip_h = fl; line_start = 1'b1; draw_x = 10'(dx);
    @(posedge Clk); #1;
    line_start = 1'b0;
    flip_h = ~fl;
    nbusy = 0;
    for (int k = 1; k <= 40; k++) begin
      if (!busy) break;
      nbusy++;
      if (hit && k <= 16) check("fetch_addr", int'(rom_addr), row*16 + k - 1);
      else if (!hit)      check("miss_addr_hold", int'(rom_addr), a0);
      check("front_hold", int'(pix_index), exp_idx(dx));
      if (k == abort_after) return;
      @(posedge Clk); #1;
    end
    check("busy_cycles", nbusy, hit ? 18 : 1);
    fhit_m = hit;
    if (hit)
      for (int i = 0; i < 16; i++) front_m[i] = int'(rom[row*16 + (fl ? 15 - i : i)]);
  endtask

  task automatic scan(input int sx);
    int e;
    @(negedge Clk);
    spr_x = 10'(sx);
    for (int dx = sx - 2; dx <= sx + 17; dx++) begin
      if (dx < 0 || dx > 1023) continue;
      @(negedge Clk); draw_x = 10'(dx);
      @(posedge Clk); #1;
      e = exp_idx(dx);
      check("pix_index", int'(pix_index), e);
      check("pix_opaque", int'(pix_opaque), (e != 0) ? 1 : 0);
    end
  endtask

  initial begin
    int sy, ny, sx;
    for (int i = 0; i < 256; i++) rom[i] = 4'($urandom_range(1, 15));
    for (int i = 0; i < 256; i += 7) rom[i] = 4'h0;
    rom[51] = 4'h0; rom[50] = 4'h9; rom[52] = 4'h5; rom[49] = 4'h3;
    for (int i = 0; i < 16; i++) front_m[i] = 0;
    fhit_m = 1'b0;

    Reset = 1'b1; line_start = 1'b0; next_y = '0; spr_x = '0; spr_y = '0;
    flip_h = 1'b0; draw_x = '0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_pix_index", int'(pix_index), 0);
    check("rst_pix_opaque", int'(pix_opaque), 0);
    repeat (3) @(posedge Clk);
    @(negedge Clk); Reset = 1'b0;

    spr_y = 10'd100; spr_x = 10'd200;
    do_line(103, 1'b0, 200, 0); scan(200);
    do_line(103, 1'b1, 200, 0); scan(200);
    do_line(99,  1'b0, 205, 0); scan(200);
    do_line(116, 1'b0, 205, 0); scan(200);

    // reset in the middle of a fetch, column 5 being addressed
    do_line(103, 1'b0, 204, 0);
    do_line(103, 1'b0, 204, 6);
    check("pre_reset_addr", int'(rom_addr), 53);
    check("pre_reset_opaque", int'(pix_opaque), 1);
    #1 Reset = 1'b1;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_opaque", int'(pix_opaque), 0);
    check("async_index", int'(pix_index), 0);
    check("async_rom_addr", int'(rom_addr), 0);
    @(negedge Clk); Reset = 1'b0;
    fhit_m = 1'b0;
    scan(200);
    do_line(103, 1'b0, 203, 0); scan(200);

    // restart mid-fetch with a different row
    do_line(103, 1'b1, 207, 7);
    do_line(105, 1'b0, 207, 0); scan(200);

    for (int n = 0; n < 20; n++) begin
      sy = $urandom_range(0, 900);
      ny = sy + $urandom_range(0, 20) - 2;
      if (ny < 0) ny = 0;
      sx = $urandom_range(0, 1023);
      spr_y = 10'(sy);
      spr_x = 10'(sx);
      do_line(ny, 1'($urandom_range(0, 1)), (sx + $urandom_range(0, 15)) % 1024, 0);
      scan(sx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mario_sprite_linebuf.md
Name: mario_sprite_linebuf

Overview:
- Per-scanline sprite fetch stage for the Mario sprite; feeds the 4-bit palette index to the palette lookup, which turns it into 12-bit RGB.
- During horizontal blanking it reads one 16-pixel row of the sprite ROM into a back line buffer, then swaps that row to the front buffer.
- During active video it returns, for each draw_x, the palette index and an opaque flag, so the mixer can choose sprite or background.

Parameters:
- SPR_W, 16, sprite width in pixels; also the line buffer depth.
- SPR_H, 16, sprite height in rows.
- TRANSP_INDEX, 4'h0, palette index treated as transparent.
- ROM_AW, $clog2(SPR_W*SPR_H), sprite ROM address width.

Ports:
- Clk  in  1  system/pixel clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- line_start  in  1  one-cycle pulse at the start of hblank; begins a fetch for next_y.
- next_y  in  10  scanline to be displayed after this hblank.
- spr_x  in  10  sprite left column, screen coordinates.
- spr_y  in  10  sprite top row, screen coordinates.
- flip_h  in  1  mirror the sprite horizontally; sampled on line_start.
- rom_addr  out  ROM_AW  sprite ROM read address.
- rom_q  in  4  ROM data; valid exactly 1 cycle after rom_addr.
- draw_x  in  10  current active-video column.
- pix_index  out  4  palette index for the pixel at draw_x delayed by 1 cycle.
- pix_opaque  out  1  high when the sprite covers that pixel and the index is not TRANSP_INDEX.
- busy  out  1  high while a fetch is in progress.

Behaviour:
- Reset (async): state=IDLE; rom_addr=0; pix_index=0; pix_opaque=0; busy=0; front_hit=0; fetch counter=0. Buffer contents are don't-care, because front_hit=0 masks them.
- Range test on line_start:
  - Compute hit = (next_y >= spr_y) && (next_y < spr_y+SPR_H), using 11-bit arithmetic so the sum never wraps.
  - Latch row = next_y - spr_y (low bits), flip_h and hit.
- FSM IDLE → FETCH (on line_start with hit=1):
  - For col=0..SPR_W-1 on consecutive cycles: rom_addr = row*SPR_W + col.
  - One cycle later, rom_q is written to back[flip ? SPR_W-1-col : col].
- FETCH → COMMIT after the last write, which lands SPR_W+1 cycles after line_start.
- COMMIT (1 cycle): front <= back; front_hit <= 1; → IDLE.
- Miss lines: on line_start with hit=0, go IDLE → COMMIT directly. The next cycle front_hit <= 0 and no ROM reads are issued.
- busy is high in FETCH and COMMIT.
- Total latency, line_start to new row visible: SPR_W+2 cycles on a hit, 2 cycles on a miss. It must finish within hblank (160 cycles at 640 wide).
- line_start during FETCH/COMMIT: abort the current fetch, relatch inputs, restart at col=0. The front buffer is unchanged until the new COMMIT.
- Output path, registered, 1-cycle latency:
  - in_x = front_hit && (draw_x >= spr_x) && (draw_x < spr_x+SPR_W), 11-bit compare.
  - pix_index <= in_x ? front[draw_x - spr_x] : 0.
  - pix_opaque <= in_x && (front[draw_x - spr_x] != TRANSP_INDEX).
  - Sprites partly off the right edge (spr_x > 640-SPR_W) clip naturally.
- Inputs spr_x, spr_y and flip_h may change at any time. The fetch uses only the values latched on line_start; the output compare uses live spr_x.
- rom_addr holds its last value outside FETCH.

Test Plan:
- Reset asserted mid-FETCH (at col 5) → busy=0, pix_opaque=0 immediately, with no clock edge required; a later line hit fetches the full row normally.
- spr_y=100, next_y=103, flip_h=0, line_start → rom_addr steps 48..63 on cycles 1..16; busy low at cycle 18; with spr_x=200, draw_x=200..215 gives pix_index = ROM[48..63] one cycle later.
- Same as above with flip_h=1 → draw_x=200 gives ROM[63] and draw_x=215 gives ROM[48]; draw_x=199 and draw_x=216 give pix_opaque=0.
- next_y=99 or next_y=116 with spr_y=100 → no rom_addr activity, busy high for 1 cycle, pix_opaque=0 over the whole line.
- Row containing index 0 at col 3 → pix_opaque=0 at draw_x=spr_x+3; neighbouring nonzero pixels give pix_opaque=1.
- Second line_start at cycle 7 of a fetch, with next_y changed to row 5 → addresses restart at 80; the previous front row stays displayed until the new commit.
